// File: rtl/fc_layer_par_if.sv
// Element streams of fc_layer_par: s_* carries x[n] into the layer, m_* carries y[m] out.
interface fc_layer_par_if #(
    parameter int W = 16
) ();
    logic         s_valid;
    logic         s_ready;
    logic [W-1:0] data_in;
    logic         m_valid;
    logic         m_ready;
    logic [W-1:0] data_out;

    modport slave (
        input  s_valid, data_in, m_ready,
        output s_ready, m_valid, data_out
    );

    modport master (
        output s_valid, data_in, m_ready,
        input  s_ready, m_valid, data_out
    );
endinterface

// File: rtl/fc_layer_par.sv
// Fully-connected layer y[m] = act(b[m] + sum_n W[m][n]*x[n]) with P parallel MAC lanes and
// config-loaded weight/bias RAM; outputs saturated to W bits, optional ReLU.
module fc_layer_par #(
    parameter int W     = 16,
    parameter int N     = 8,
    parameter int M     = 16,
    parameter int P     = 4,
    parameter int ACC_W = 40,
    parameter bit RELU  = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    fc_layer_par_if.slave          bus,
    input  logic                   cfg_we,
    input  logic                   cfg_sel,
    input  logic [$clog2(M*N)-1:0] cfg_addr,
    input  logic [W-1:0]           cfg_data,
    output logic                   busy
);
    localparam int G    = M / P;
    localparam int ROWS = G * N;
    localparam int NW   = (N > 1) ? $clog2(N) : 1;
    localparam int CW   = $clog2(N + 2);
    localparam int GW   = (G > 1) ? $clog2(G) : 1;
    localparam int PW   = (P > 1) ? $clog2(P) : 1;
    localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int MW   = (M > 1) ? $clog2(M) : 1;

    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-W+1){1'b1}}, {(W-1){1'b0}}};

    if (M % P != 0) begin : g_chk_mp
        $error("fc_layer_par: M must be a multiple of P");
    end
    if (ACC_W < 2 * W + $clog2(N + 1)) begin : g_chk_acc
        $error("fc_layer_par: ACC_W too narrow for an overflow-free dot product");
    end

    typedef enum logic [1:0] {LOAD, COMPUTE, OUT} state_t;

    state_t              state;
    state_t              state_nxt;
    logic [NW-1:0]       in_cnt;
    logic [CW-1:0]       cyc;
    logic [GW-1:0]       grp;
    logic [PW-1:0]       out_cnt;
    logic [W-1:0]        data_out_q;
    logic [W-1:0]        xmem [N];
    logic [W-1:0]        x_q;
    logic [P-1:0][W-1:0] res_q;
    logic [P-1:0][W-1:0] res_nxt;

    logic          in_xfer;
    logic          out_xfer;
    logic          last_in;
    logic          last_cyc;
    logic          last_lane;
    logic          last_grp;
    logic          rd_en;
    logic [RW-1:0] rd_row;

    assign bus.s_ready  = (state == LOAD);
    assign bus.m_valid  = (state == OUT);
    assign bus.data_out = data_out_q;
    assign busy         = (state != LOAD);

    assign in_xfer   = bus.s_valid && bus.s_ready;
    assign out_xfer  = bus.m_valid && bus.m_ready;
    assign last_in   = (in_cnt == NW'(N - 1));
    assign last_cyc  = (cyc == CW'(N + 1));
    assign last_lane = (out_cnt == PW'(P - 1));
    assign last_grp  = (grp == GW'(G - 1));

    // Reads for element n are issued in cycle n so the operands land in cycle n+1.
    assign rd_en  = (state == COMPUTE) && (cyc < CW'(N));
    assign rd_row = RW'(32'(grp) * N + 32'(cyc));

    // Weight W[m][n] lives in lane m%P at row (m/P)*N+n; bias b[m] in lane m%P at row m/P.
    logic [31:0]   cfg_a;
    logic [31:0]   cfg_m;
    logic [31:0]   cfg_bm;
    logic [PW-1:0] cfg_wbank;
    logic [PW-1:0] cfg_bbank;
    logic [RW-1:0] cfg_wrow;
    logic [GW-1:0] cfg_brow;
    logic          cfg_en;
    logic          cfg_wok;
    logic          cfg_bok;

    assign cfg_en    = cfg_we && !busy && !(in_xfer && in_cnt != '0);
    assign cfg_a     = 32'(cfg_addr);
    assign cfg_m     = cfg_a / N;
    assign cfg_wbank = PW'(cfg_m % P);
    assign cfg_wrow  = RW'((cfg_m / P) * N + cfg_a % N);
    assign cfg_bm    = 32'(cfg_addr[MW-1:0]);
    assign cfg_bbank = PW'(cfg_bm % P);
    assign cfg_brow  = GW'(cfg_bm / P);
    assign cfg_wok   = cfg_en && !cfg_sel && (cfg_a < M * N);
    assign cfg_bok   = cfg_en && cfg_sel && (cfg_bm < M);

    always_ff @(posedge clk) begin
        if (reset) state <= LOAD;
        else       state <= state_nxt;
    end

    // NOTE: combinational blocks use blocking '=' and assign every output a default first,
    // so no path through the block leaves a value held and no latch is inferred.
    always_comb begin
        state_nxt = state;
        unique case (state)
            LOAD:    if (in_xfer && last_in) state_nxt = COMPUTE;
            COMPUTE: if (last_cyc) state_nxt = OUT;
            OUT:     if (out_xfer && last_lane) state_nxt = last_grp ? LOAD : COMPUTE;
            default: state_nxt = LOAD;
        endcase
    end

    // NOTE: sequential blocks use non-blocking '<=' so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_cnt     <= '0;
            cyc        <= '0;
            grp        <= '0;
            out_cnt    <= '0;
            data_out_q <= '0;
        end else begin
            case (state)
                LOAD: if (in_xfer) begin
                    in_cnt  <= last_in ? '0 : in_cnt + 1'b1;
                    cyc     <= '0;
                    grp     <= '0;
                    out_cnt <= '0;
                end
                COMPUTE: begin
                    cyc <= last_cyc ? '0 : cyc + 1'b1;
                    if (last_cyc) begin
                        out_cnt    <= '0;
                        data_out_q <= res_nxt[0];
                    end
                end
                OUT: if (out_xfer) begin
                    if (last_lane) begin
                        out_cnt <= '0;
                        if (!last_grp) grp <= grp + 1'b1;
                    end else begin
                        out_cnt    <= out_cnt + 1'b1;
                        data_out_q <= res_q[out_cnt + 1'b1];
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: storage arrays and their read/result registers are deliberately not reset; they are
    // always written before being read, and resetting them would rule out RAM inference.
    always_ff @(posedge clk) begin
        if (in_xfer) xmem[in_cnt] <= bus.data_in;
        if (rd_en)   x_q <= xmem[cyc[NW-1:0]];
    end

    for (genvar p = 0; p < P; p++) begin : g_lane
        logic [W-1:0]            wmem [ROWS];
        logic [W-1:0]            bmem [G];
        logic [W-1:0]            w_q;
        logic [W-1:0]            b_q;
        logic [W-1:0]            res_lane;
        logic [W-1:0]            sat;
        logic [2*W-1:0]          prod;
        logic [ACC_W-1:0]        prod_ext;
        logic [ACC_W-1:0]        bias_ext;
        logic signed [ACC_W-1:0] acc;

        always_ff @(posedge clk) begin
            if (cfg_wok && cfg_wbank == PW'(p)) wmem[cfg_wrow] <= cfg_data;
            if (cfg_bok && cfg_bbank == PW'(p)) bmem[cfg_brow] <= cfg_data;
            if (rd_en) begin
                w_q <= wmem[rd_row];
                b_q <= bmem[grp];
            end
            if (state == COMPUTE && last_cyc) res_lane <= sat;
        end

        // Operands sign-extended to 2W so the low 2W bits of the product are the exact signed result.
        assign prod     = {{W{w_q[W-1]}}, w_q} * {{W{x_q[W-1]}}, x_q};
        assign prod_ext = {{(ACC_W-2*W){prod[2*W-1]}}, prod};
        assign bias_ext = {{(ACC_W-W){b_q[W-1]}}, b_q};

        always_ff @(posedge clk) begin
            if (reset) begin
                acc <= '0;
            end else if (state == COMPUTE && cyc != '0 && !last_cyc) begin
                acc <= ((cyc == CW'(1)) ? bias_ext : acc) + prod_ext;
            end
        end

        always_comb begin
            if (RELU && acc < 0)   sat = '0;
            else if (acc > SAT_MAX) sat = SAT_MAX[W-1:0];
            else if (acc < SAT_MIN) sat = SAT_MIN[W-1:0];
            else                    sat = acc[W-1:0];
        end

        assign res_nxt[p] = sat;
        assign res_q[p]   = res_lane;
    end
endmodule
